// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence path: transmitter FSM states
// and the reference pattern recognised by the downstream detector.
package seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } seq_tx_state_t;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load pattern register that presents the bit after the current MSB.
// A shift rotates the contents so the register never needs a fill value.
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_d,
  input  logic [PAT_W-1:0] reload_d,
  output logic             nxt_bit
);

  logic [PAT_W-1:0] q;

  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_d;
    end else if (reload) begin
      q <= reload_d;
    end else if (shift) begin
      q <= {q[PAT_W-2:0], q[PAT_W-1]};
    end
  end

  // q[PAT_W-1] is the bit currently on the line; the next one sits just below it.
  assign nxt_bit = q[PAT_W-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first a programmable
// number of times with optional idle gaps, then pulses done_o.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             bit_o,
  output logic             bit_vld_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] REPS_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = '0;

  seq_tx_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] reps_left;
  logic [GAP_W-1:0] gap_cnt;
  logic [PAT_W-1:0] pat_r;
  logic [GAP_W-1:0] gap_r;

  logic sr_load;
  logic sr_reload;
  logic sr_shift;
  logic sr_nxt;
  logic accept;

  assign accept = (state == TX_IDLE) && start_i;

  // Frame parameters are data: captured on accept, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      pat_r <= pattern_i;
      gap_r <= gap_i;
    end
  end

  always_comb begin
    sr_load   = accept;
    sr_shift  = 1'b0;
    sr_reload = 1'b0;
    if (state == TX_SHIFT) begin
      if (idx != IDX_LAST) begin
        sr_shift = 1'b1;
      end else if (reps_left != REPS_ONE && gap_r == GAP_ZERO) begin
        sr_reload = 1'b1;
      end
    end else if (state == TX_GAP && gap_cnt == GAP_ONE) begin
      sr_reload = 1'b1;
    end
  end

  seq_shift_reg #(
    .PAT_W(PAT_W)
  ) u_shift (
    .clk     (clk),
    .load    (sr_load),
    .reload  (sr_reload),
    .shift   (sr_shift),
    .load_d  (pattern_i),
    .reload_d(pat_r),
    .nxt_bit (sr_nxt)
  );

  // Outputs are registered alongside the state so each reflects the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      idx       <= '0;
      reps_left <= '0;
      gap_cnt   <= '0;
      bit_o     <= 1'b0;
      bit_vld_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        TX_IDLE: begin
          bit_o     <= 1'b0;
          bit_vld_o <= 1'b0;
          busy_o    <= 1'b0;
          if (start_i) begin
            if (repeat_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state     <= TX_SHIFT;
              idx       <= '0;
              reps_left <= repeat_i;
              bit_o     <= pattern_i[PAT_W-1];
              bit_vld_o <= 1'b1;
              busy_o    <= 1'b1;
            end
          end
        end
        TX_SHIFT: begin
          if (idx != IDX_LAST) begin
            idx   <= idx + 1'b1;
            bit_o <= sr_nxt;
          end else if (reps_left == REPS_ONE) begin
            state     <= TX_IDLE;
            idx       <= '0;
            reps_left <= '0;
            bit_o     <= 1'b0;
            bit_vld_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
          end else if (gap_r == GAP_ZERO) begin
            // Back-to-back repeat: no bubble between the last and first bits.
            idx       <= '0;
            reps_left <= reps_left - 1'b1;
            bit_o     <= pat_r[PAT_W-1];
          end else begin
            state     <= TX_GAP;
            idx       <= '0;
            gap_cnt   <= gap_r;
            reps_left <= reps_left - 1'b1;
            bit_o     <= 1'b0;
            bit_vld_o <= 1'b0;
          end
        end
        TX_GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state     <= TX_SHIFT;
            gap_cnt   <= '0;
            bit_o     <= pat_r[PAT_W-1];
            bit_vld_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state     <= TX_IDLE;
          bit_o     <= 1'b0;
          bit_vld_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a per-cycle expectation queue built
// from frame rules, directed scenarios with literal histories, and random traffic.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [PAT_W-1:0] pattern_i = '0;
  logic [CNT_W-1:0] repeat_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic             bit_o;
  logic             bit_vld_o;
  logic             busy_o;
  logic             done_o;

  seq_pattern_tx #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .pattern_i(pattern_i),
    .repeat_i (repeat_i),
    .gap_i    (gap_i),
    .bit_o    (bit_o),
    .bit_vld_o(bit_vld_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic v;
    logic busy;
    logic done;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  int   checks = 0;
  int   errors = 0;
  int   tcyc = 0;
  int   rel = 0;
  int   vld_cnt = 0;
  int   done_cnt = 0;
  int   done_at = -1;
  logic [31:0] vld_h, bit_h, busy_h, done_h;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // A frame is rep copies of the pattern separated by gap idle-busy cycles, then one done cycle.
  task automatic push_frame(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    exp_t e;
    for (int r = 0; r < rep; r++) begin
      for (int i = 0; i < PAT_W; i++) begin
        e.b = ((int'(pat) >> (PAT_W - 1 - i)) & 1) != 0;
        e.v = 1'b1; e.busy = 1'b1; e.done = 1'b0;
        q.push_back(e);
      end
      if (r < rep - 1) begin
        for (int g = 0; g < gap; g++) begin
          e = '0; e.busy = 1'b1;
          q.push_back(e);
        end
      end
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic cyc(input bit st, input logic [PAT_W-1:0] pat, input int rep, input int gap,
                     input bit r);
    bit acc;
    rst = r; start_i = st; pattern_i = pat;
    repeat_i = CNT_W'(rep); gap_i = GAP_W'(gap);
    acc = st && !r && !cur.busy;
    @(posedge clk);
    if (r) begin
      q.delete();
      cur = '0;
    end else begin
      if (acc) push_frame(pat, rep, gap);
      cur = (q.size() > 0) ? q.pop_front() : exp_t'('0);
    end
    #1;
    tcyc++; rel++;
    chk($sformatf("c%0d_bit", tcyc), int'(bit_o), int'(cur.b));
    chk($sformatf("c%0d_vld", tcyc), int'(bit_vld_o), int'(cur.v));
    chk($sformatf("c%0d_busy", tcyc), int'(busy_o), int'(cur.busy));
    chk($sformatf("c%0d_done", tcyc), int'(done_o), int'(cur.done));
    if (rel < 32) begin
      vld_h[rel] = bit_vld_o; bit_h[rel] = bit_o;
      busy_h[rel] = busy_o; done_h[rel] = done_o;
    end
    if (bit_vld_o) vld_cnt++;
    if (done_o) begin
      done_cnt++;
      if (done_at < 0) done_at = rel;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, PAT_W'($urandom), $urandom_range(0, 5), 0, 1'b0);
  endtask

  task automatic begin_dir();
    idle(3);
    rel = 0; vld_cnt = 0; done_cnt = 0; done_at = -1;
    vld_h = '0; bit_h = '0; busy_h = '0; done_h = '0;
  endtask

  initial begin
    int fires;
    bit st, r;
    int rep;
    vld_h = '0; bit_h = '0; busy_h = '0; done_h = '0;

    cyc(1'b0, '0, 0, 0, 1'b1);
    cyc(1'b1, PAT_1011, 3, 0, 1'b1);
    chk("reset_vld", int'(bit_vld_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);

    // 1: single repeat
    begin_dir();
    cyc(1'b1, PAT_1011, 1, 0, 1'b0);
    idle(8);
    chk("t1_vld_hist", int'(vld_h), 32'h0000_001E);
    chk("t1_bit_hist", int'(bit_h), 32'h0000_001A);
    chk("t1_busy_hist", int'(busy_h), 32'h0000_001E);
    chk("t1_done_hist", int'(done_h), 32'h0000_0020);

    // 2: three back-to-back repeats
    begin_dir();
    cyc(1'b1, PAT_1011, 3, 0, 1'b0);
    idle(16);
    chk("t2_vld_hist", int'(vld_h), 32'h0000_1FFE);
    chk("t2_bit_hist", int'(bit_h), 32'h0000_1BBA);
    chk("t2_done_hist", int'(done_h), 32'h0000_2000);
    fires = 0;
    for (int k = 4; k <= 12; k++)
      if ({bit_h[k-3], bit_h[k-2], bit_h[k-1], bit_h[k]} == PAT_1011) fires++;
    chk("t2_detector_fires", fires, 3);

    // 3: two repeats with a gap of 3
    begin_dir();
    cyc(1'b1, PAT_1011, 2, 3, 1'b0);
    idle(16);
    chk("t3_vld_hist", int'(vld_h), 32'h0000_0F1E);
    chk("t3_bit_hist", int'(bit_h), 32'h0000_0D1A);
    chk("t3_busy_hist", int'(busy_h), 32'h0000_0FFE);
    chk("t3_done_hist", int'(done_h), 32'h0000_1000);

    // 4: empty frame
    begin_dir();
    cyc(1'b1, PAT_1011, 0, 2, 1'b0);
    idle(6);
    chk("t4_vld_hist", int'(vld_h), 0);
    chk("t4_busy_hist", int'(busy_h), 0);
    chk("t4_done_hist", int'(done_h), 32'h0000_0002);

    // 5a: start re-pulsed mid-frame is ignored
    begin_dir();
    cyc(1'b1, PAT_1011, 1, 0, 1'b0);
    cyc(1'b0, '0, 0, 0, 1'b0);
    cyc(1'b1, 4'b0000, 2, 0, 1'b0);
    idle(10);
    chk("t5_bit_hist", int'(bit_h), 32'h0000_001A);
    chk("t5_vld_hist", int'(vld_h), 32'h0000_001E);
    chk("t5_done_count", done_cnt, 1);

    // 5b: reset mid-frame discards the frame
    begin_dir();
    cyc(1'b1, PAT_1011, 2, 1, 1'b0);
    cyc(1'b0, '0, 0, 0, 1'b0);
    cyc(1'b0, '0, 0, 0, 1'b0);
    cyc(1'b0, '0, 0, 0, 1'b1);
    idle(12);
    chk("t5r_vld_hist", int'(vld_h), 32'h0000_000E);
    chk("t5r_busy_hist", int'(busy_h), 32'h0000_000E);
    chk("t5r_done_hist", int'(done_h), 0);

    // 6: start held through the done cycle chains the next frame
    begin_dir();
    cyc(1'b1, PAT_1011, 1, 0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 4'b1100, 1, 0, 1'b0);
    idle(8);
    chk("t6_vld_hist", int'(vld_h), 32'h0000_03DE);
    chk("t6_bit_hist", int'(bit_h), 32'h0000_00DA);
    chk("t6_done_hist", int'(done_h), 32'h0000_0420);

    // maximum repeat count
    begin_dir();
    cyc(1'b1, 4'b0110, 255, 0, 1'b0);
    idle(1030);
    chk("max_rep_vld_count", vld_cnt, 255 * PAT_W);
    chk("max_rep_done_cycle", done_at, 255 * PAT_W + 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 149) == 0);
      rep = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      cyc(st, PAT_W'($urandom), rep,
          ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
